// File: rtl/vm_pkg.sv
// Shared types and defaults for the vending dispense controller.
// The tie-break constants say which requester wins the next simultaneous request.
package vm_pkg;

    localparam int VM_NUM_SLOTS = 8;
    localparam int VM_SEL_W     = 3;
    localparam int VM_CNT_W     = 4;

    localparam logic PRIO_VEND = 1'b0;
    localparam logic PRIO_SVC  = 1'b1;

    typedef enum logic [2:0] {
        IDLE,
        VEND_RUN,
        VEND_DONE,
        VEND_FAIL,
        SVC_UPD
    } vmState_t;

endpackage

// File: rtl/vm_inventory_bank.sv
// Per-slot stock counters with one decrement port and one saturating add port.
// Also provides a combinational count read mux, the occupancy bitmap and the all-empty flag.
module vm_inventory_bank #(
    parameter int NUM_SLOTS = 8,
    parameter int SEL_W     = 3,
    parameter int CNT_W     = 4,
    parameter int INIT_CNT  = 4
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 dec_en,
    input  logic [SEL_W-1:0]     dec_sel,
    input  logic                 add_en,
    input  logic [SEL_W-1:0]     add_sel,
    input  logic [CNT_W-1:0]     add_qty,
    input  logic [SEL_W-1:0]     rd_sel,
    output logic [CNT_W-1:0]     rd_cnt,
    output logic [NUM_SLOTS-1:0] inventory,
    output logic                 inventory_empty
);

    logic [CNT_W-1:0] r_count  [NUM_SLOTS];
    logic [CNT_W-1:0] w_addVal [NUM_SLOTS];

    // The sum is formed one bit wider so a carry out clamps the slot to full scale.
    always_comb begin
        logic [CNT_W:0] w_sum;
        for (int i = 0; i < NUM_SLOTS; i++) begin
            w_sum       = {1'b0, r_count[i]} + {1'b0, add_qty};
            w_addVal[i] = w_sum[CNT_W] ? {CNT_W{1'b1}} : w_sum[CNT_W-1:0];
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < NUM_SLOTS; i++) begin
                r_count[i] <= CNT_W'(INIT_CNT);
            end
        end else begin
            for (int i = 0; i < NUM_SLOTS; i++) begin
                if (dec_en && (dec_sel == SEL_W'(i))) begin
                    r_count[i] <= r_count[i] - 1'b1;
                end else if (add_en && (add_sel == SEL_W'(i))) begin
                    r_count[i] <= w_addVal[i];
                end
            end
        end
    end

    always_comb begin
        rd_cnt = '0;
        for (int i = 0; i < NUM_SLOTS; i++) begin
            if (rd_sel == SEL_W'(i)) begin
                rd_cnt = r_count[i];
            end
            inventory[i] = (r_count[i] != '0);
        end
        inventory_empty = ~|inventory;
    end

endmodule

// File: rtl/vm_dispense_ctrl.sv
// Dispense sequencer: arbitrates customer vends against service restocks,
// runs the motor with a drop timeout and owns the inventory bank.
module vm_dispense_ctrl
    import vm_pkg::*;
#(
    parameter int NUM_SLOTS = VM_NUM_SLOTS,
    parameter int SEL_W     = VM_SEL_W,
    parameter int CNT_W     = VM_CNT_W,
    parameter int INIT_CNT  = 4,
    parameter int TIMEOUT   = 16
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 vend_req,
    input  logic [SEL_W-1:0]     vend_sel,
    output logic                 vend_ack,
    output logic                 vend_done,
    output logic                 vend_fail,
    input  logic                 svc_req,
    input  logic [SEL_W-1:0]     svc_sel,
    input  logic [CNT_W-1:0]     svc_qty,
    output logic                 svc_ack,
    output logic                 motor_en,
    output logic [SEL_W-1:0]     motor_sel,
    input  logic                 drop_sense,
    output logic [NUM_SLOTS-1:0] inventory,
    output logic                 inventory_empty
);

    localparam int TMR_W  = $clog2(TIMEOUT + 1);
    localparam int SEL1_W = SEL_W + 1;

    vmState_t         r_state;
    vmState_t         w_stateNext;
    logic             r_prio;
    logic             r_vendAck;
    logic [SEL_W-1:0] r_motorSel;
    logic [SEL_W-1:0] r_svcSel;
    logic [CNT_W-1:0] r_svcQty;
    logic [TMR_W-1:0] r_timer;
    logic             w_grantVend;
    logic             w_grantSvc;
    logic             w_vendOk;
    logic             w_dec;
    logic             w_add;
    logic [CNT_W-1:0] w_rdCnt;

    vm_inventory_bank #(
        .NUM_SLOTS(NUM_SLOTS),
        .SEL_W    (SEL_W),
        .CNT_W    (CNT_W),
        .INIT_CNT (INIT_CNT)
    ) u_bank (
        .clk            (clk),
        .reset          (reset),
        .dec_en         (w_dec),
        .dec_sel        (r_motorSel),
        .add_en         (w_add),
        .add_sel        (r_svcSel),
        .add_qty        (r_svcQty),
        .rd_sel         (vend_sel),
        .rd_cnt         (w_rdCnt),
        .inventory      (inventory),
        .inventory_empty(inventory_empty)
    );

    assign w_vendOk = ({1'b0, vend_sel} < SEL1_W'(NUM_SLOTS)) && (w_rdCnt != '0);

    // A rejected vend sits in VEND_FAIL for its ack cycle first, so fail is held off while ack is up.
    always_comb begin
        w_stateNext = r_state;
        w_grantVend = 1'b0;
        w_grantSvc  = 1'b0;
        w_dec       = 1'b0;
        w_add       = 1'b0;
        case (r_state)
            IDLE: begin
                if (vend_req && (!svc_req || (r_prio == PRIO_VEND))) begin
                    w_grantVend = 1'b1;
                    w_stateNext = w_vendOk ? VEND_RUN : VEND_FAIL;
                end else if (svc_req) begin
                    w_grantSvc  = 1'b1;
                    w_stateNext = SVC_UPD;
                end
            end
            VEND_RUN: begin
                if (drop_sense) begin
                    w_dec       = 1'b1;
                    w_stateNext = VEND_DONE;
                end else if (r_timer == TMR_W'(TIMEOUT - 1)) begin
                    w_stateNext = VEND_FAIL;
                end
            end
            VEND_DONE: w_stateNext = IDLE;
            VEND_FAIL: begin
                if (!r_vendAck) begin
                    w_stateNext = IDLE;
                end
            end
            SVC_UPD: begin
                w_add       = 1'b1;
                w_stateNext = IDLE;
            end
            default: w_stateNext = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state    <= IDLE;
            r_prio     <= PRIO_VEND;
            r_vendAck  <= 1'b0;
            r_motorSel <= '0;
            r_svcSel   <= '0;
            r_svcQty   <= '0;
            r_timer    <= '0;
        end else begin
            r_state   <= w_stateNext;
            r_vendAck <= w_grantVend;
            if (w_grantVend) begin
                r_prio     <= PRIO_SVC;
                r_motorSel <= vend_sel;
                r_timer    <= '0;
            end else if (r_state == VEND_RUN) begin
                r_timer <= r_timer + 1'b1;
            end
            if (w_grantSvc) begin
                r_prio   <= PRIO_VEND;
                r_svcSel <= svc_sel;
                r_svcQty <= svc_qty;
            end
        end
    end

    assign vend_ack  = r_vendAck;
    assign vend_done = (r_state == VEND_DONE);
    assign vend_fail = (r_state == VEND_FAIL) && !r_vendAck;
    assign svc_ack   = (r_state == SVC_UPD);
    assign motor_en  = (r_state == VEND_RUN);
    assign motor_sel = r_motorSel;

endmodule

// File: tb/tb_vm_dispense_ctrl.sv
// Scenario bench for vm_dispense_ctrl: expected grants, outcomes and motor-on lengths are
// queued from a small stock/priority model when requests are raised, then popped as the DUT answers.
module tb_vm_dispense_ctrl;
    import vm_pkg::*;

    localparam int NUM_SLOTS = 8;
    localparam int SEL_W     = 3;
    localparam int CNT_W     = 4;
    localparam int INIT_CNT  = 4;
    localparam int TIMEOUT   = 16;
    localparam int CNT_MAX   = (1 << CNT_W) - 1;

    logic                 clk = 1'b0;
    logic                 reset;
    logic                 vend_req;
    logic [SEL_W-1:0]     vend_sel;
    logic                 vend_ack;
    logic                 vend_done;
    logic                 vend_fail;
    logic                 svc_req;
    logic [SEL_W-1:0]     svc_sel;
    logic [CNT_W-1:0]     svc_qty;
    logic                 svc_ack;
    logic                 motor_en;
    logic [SEL_W-1:0]     motor_sel;
    logic                 drop_sense;
    logic [NUM_SLOTS-1:0] inventory;
    logic                 inventory_empty;

    int   checkCount = 0;
    int   passCount  = 0;
    int   modelCnt [NUM_SLOTS];
    logic modelPrio;
    int   expGrant   [$];
    int   expOutcome [$];
    int   expMotor   [$];

    always #5 clk = ~clk;

    vm_dispense_ctrl #(
        .NUM_SLOTS(NUM_SLOTS),
        .SEL_W    (SEL_W),
        .CNT_W    (CNT_W),
        .INIT_CNT (INIT_CNT),
        .TIMEOUT  (TIMEOUT)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .vend_req       (vend_req),
        .vend_sel       (vend_sel),
        .vend_ack       (vend_ack),
        .vend_done      (vend_done),
        .vend_fail      (vend_fail),
        .svc_req        (svc_req),
        .svc_sel        (svc_sel),
        .svc_qty        (svc_qty),
        .svc_ack        (svc_ack),
        .motor_en       (motor_en),
        .motor_sel      (motor_sel),
        .drop_sense     (drop_sense),
        .inventory      (inventory),
        .inventory_empty(inventory_empty)
    );

    function automatic logic [NUM_SLOTS-1:0] modelInv();
        logic [NUM_SLOTS-1:0] v;
        for (int i = 0; i < NUM_SLOTS; i++) v[i] = (modelCnt[i] != 0);
        return v;
    endfunction

    task automatic resetModel();
        for (int i = 0; i < NUM_SLOTS; i++) modelCnt[i] = INIT_CNT;
        modelPrio = PRIO_VEND;
        expGrant.delete();
        expOutcome.delete();
        expMotor.delete();
    endtask

    task automatic startVend(input int sel, input int dropDelay);
        if (modelCnt[sel] == 0) begin
            expOutcome.push_back(2);
            expMotor.push_back(0);
        end else if (dropDelay >= 0 && dropDelay < TIMEOUT) begin
            expOutcome.push_back(1);
            expMotor.push_back(dropDelay + 1);
            modelCnt[sel]--;
        end else begin
            expOutcome.push_back(2);
            expMotor.push_back(TIMEOUT);
        end
        vend_sel = SEL_W'(sel);
        vend_req = 1'b1;
    endtask

    task automatic startSvc(input int sel, input int qty);
        if (sel < NUM_SLOTS) begin
            modelCnt[sel] = (modelCnt[sel] + qty > CNT_MAX) ? CNT_MAX : modelCnt[sel] + qty;
        end
        svc_sel = SEL_W'(sel);
        svc_qty = CNT_W'(qty);
        svc_req = 1'b1;
    endtask

    task automatic waitAck(output int which);
        which = -1;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            if (vend_ack && svc_ack) begin which = 2; break; end
            if (vend_ack) begin which = 0; break; end
            if (svc_ack) begin which = 1; break; end
        end
    endtask

    // Entered at the negedge of the vend_ack cycle; drives drop_sense dropDelay motor cycles in.
    task automatic completeVend(input int sel, input int dropDelay, input string name);
        int motorCycles;
        int outcome;
        int selBad;
        int expOut;
        int expMot;
        vend_req    = 1'b0;
        motorCycles = 0;
        outcome     = 0;
        selBad      = 0;
        for (int c = 0; c < 3 * TIMEOUT && outcome == 0; c++) begin
            if (motor_en) begin
                motorCycles++;
                if (motor_sel !== SEL_W'(sel)) selBad++;
            end
            drop_sense = motor_en && (dropDelay >= 0) && (motorCycles - 1 == dropDelay);
            @(negedge clk);
            drop_sense = 1'b0;
            if (vend_done && vend_fail) outcome = 3;
            else if (vend_done) outcome = 1;
            else if (vend_fail) outcome = 2;
        end
        expOut = expOutcome.pop_front();
        expMot = expMotor.pop_front();
        checkCount++;
        if (outcome !== expOut)
            $display("[TB] FAIL %s_outcome: got %0d expected %0d (1=done 2=fail)", name, outcome, expOut);
        else passCount++;
        checkCount++;
        if (motorCycles !== expMot)
            $display("[TB] FAIL %s_motor_cycles: got %0d expected %0d", name, motorCycles, expMot);
        else passCount++;
        checkCount++;
        if (selBad !== 0)
            $display("[TB] FAIL %s_motor_sel: got %0d wrong cycles expected 0", name, selBad);
        else passCount++;
        @(negedge clk);
        checkCount++;
        if ((vend_done | vend_fail) !== 1'b0)
            $display("[TB] FAIL %s_single_pulse: got done=%b fail=%b expected 0/0", name, vend_done, vend_fail);
        else passCount++;
        checkCount++;
        if ((int'(dut.u_bank.r_count[sel]) !== modelCnt[sel]) || (inventory !== modelInv()))
            $display("[TB] FAIL %s_stock: got count=%0d inv=%b expected count=%0d inv=%b",
                     name, dut.u_bank.r_count[sel], inventory, modelCnt[sel], modelInv());
        else passCount++;
    endtask

    task automatic completeSvc(input int sel, input string name);
        svc_req = 1'b0;
        @(negedge clk);
        checkCount++;
        if (svc_ack !== 1'b0)
            $display("[TB] FAIL %s_svc_ack_len: got %b expected 0", name, svc_ack);
        else passCount++;
        checkCount++;
        if ((int'(dut.u_bank.r_count[sel]) !== modelCnt[sel]) || (inventory !== modelInv()))
            $display("[TB] FAIL %s_restock: got count=%0d inv=%b expected count=%0d inv=%b",
                     name, dut.u_bank.r_count[sel], inventory, modelCnt[sel], modelInv());
        else passCount++;
    endtask

    task automatic doVend(input int sel, input int dropDelay, input string name);
        int which;
        int exp;
        expGrant.push_back(0);
        modelPrio = PRIO_SVC;
        startVend(sel, dropDelay);
        waitAck(which);
        exp = expGrant.pop_front();
        checkCount++;
        if (which !== exp)
            $display("[TB] FAIL %s_grant: got %0d expected %0d (0=vend 1=svc)", name, which, exp);
        else passCount++;
        if (which == 0) completeVend(sel, dropDelay, name);
        else begin
            vend_req = 1'b0;
            expOutcome.delete();
            expMotor.delete();
        end
    endtask

    task automatic doSvc(input int sel, input int qty, input string name);
        int which;
        int exp;
        expGrant.push_back(1);
        modelPrio = PRIO_VEND;
        startSvc(sel, qty);
        waitAck(which);
        exp = expGrant.pop_front();
        checkCount++;
        if (which !== exp)
            $display("[TB] FAIL %s_grant: got %0d expected %0d (0=vend 1=svc)", name, which, exp);
        else passCount++;
        if (which == 1) completeSvc(sel, name);
        else svc_req = 1'b0;
    endtask

    task automatic doTie(input int vsel, input int vdrop, input int ssel, input int sqty, input string name);
        int first;
        int which;
        int exp;
        first = (modelPrio == PRIO_VEND) ? 0 : 1;
        expGrant.push_back(first);
        expGrant.push_back(1 - first);
        modelPrio = (first == 0) ? PRIO_VEND : PRIO_SVC;
        startVend(vsel, vdrop);
        startSvc(ssel, sqty);
        for (int k = 0; k < 2; k++) begin
            waitAck(which);
            exp = expGrant.pop_front();
            checkCount++;
            if (which !== exp)
                $display("[TB] FAIL %s_grant%0d: got %0d expected %0d (0=vend 1=svc)", name, k, which, exp);
            else passCount++;
            if (which == 0) completeVend(vsel, vdrop, name);
            else if (which == 1) completeSvc(ssel, name);
            else begin
                vend_req = 1'b0;
                svc_req  = 1'b0;
                expGrant.delete();
                expOutcome.delete();
                expMotor.delete();
                break;
            end
        end
    endtask

    task automatic test_reset();
        reset      = 1'b1;
        vend_req   = 1'b0;
        vend_sel   = '0;
        svc_req    = 1'b0;
        svc_sel    = '0;
        svc_qty    = '0;
        drop_sense = 1'b0;
        resetModel();
        repeat (2) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        checkCount++;
        if ({vend_ack, vend_done, vend_fail, svc_ack, motor_en} !== 5'b0)
            $display("[TB] FAIL reset_pulses: got %b expected 00000",
                     {vend_ack, vend_done, vend_fail, svc_ack, motor_en});
        else passCount++;
        checkCount++;
        if (motor_sel !== '0)
            $display("[TB] FAIL reset_motor_sel: got %0d expected 0", motor_sel);
        else passCount++;
        checkCount++;
        if (inventory !== modelInv())
            $display("[TB] FAIL reset_inventory: got %b expected %b", inventory, modelInv());
        else passCount++;
        checkCount++;
        if (inventory_empty !== 1'b0)
            $display("[TB] FAIL reset_empty: got %b expected 0", inventory_empty);
        else passCount++;
    endtask

    task automatic test_vend_done();
        doVend(1, 3, "vend_s1");
    endtask

    task automatic test_timeout();
        doVend(2, -1, "timeout_s2");
    endtask

    task automatic test_drain_empty();
        for (int i = 0; i < INIT_CNT; i++) doVend(0, i, "drain_s0");
        doVend(0, 0, "empty_s0");
        checkCount++;
        if (inventory_empty !== 1'b0)
            $display("[TB] FAIL drain_empty_flag: got %b expected 0", inventory_empty);
        else passCount++;
    endtask

    task automatic test_arbitration();
        doTie(4, 1, 5, 1, "tie_a");
        doVend(0, 0, "arb_single");
        doTie(6, 0, 7, 2, "tie_b");
    endtask

    task automatic test_restock();
        doSvc(3, 14, "svc_sat");
        doSvc(3, 0, "svc_zero");
    endtask

    task automatic test_reset_midvend();
        int which;
        int spur;
        vend_sel = SEL_W'(1);
        vend_req = 1'b1;
        waitAck(which);
        vend_req = 1'b0;
        checkCount++;
        if (which !== 0)
            $display("[TB] FAIL midreset_grant: got %0d expected 0", which);
        else passCount++;
        repeat (3) @(negedge clk);
        checkCount++;
        if (motor_en !== 1'b1)
            $display("[TB] FAIL midreset_motor_before: got %b expected 1", motor_en);
        else passCount++;
        #2 reset = 1'b1;
        #1;
        resetModel();
        checkCount++;
        if ({motor_en, motor_sel} !== {1'b0, SEL_W'(0)})
            $display("[TB] FAIL midreset_motor_async: got en=%b sel=%0d expected 0/0", motor_en, motor_sel);
        else passCount++;
        for (int i = 0; i < NUM_SLOTS; i++) begin
            checkCount++;
            if (int'(dut.u_bank.r_count[i]) !== modelCnt[i])
                $display("[TB] FAIL midreset_count%0d: got %0d expected %0d", i, dut.u_bank.r_count[i], modelCnt[i]);
            else passCount++;
        end
        @(negedge clk);
        reset = 1'b0;
        spur  = 0;
        repeat (TIMEOUT + 4) begin
            @(negedge clk);
            if (vend_ack | vend_done | vend_fail | svc_ack | motor_en) spur++;
        end
        checkCount++;
        if (spur !== 0)
            $display("[TB] FAIL midreset_quiet: got %0d active cycles expected 0", spur);
        else passCount++;
    endtask

    initial begin
        test_reset();
        test_vend_done();
        test_timeout();
        test_drain_empty();
        test_arbitration();
        test_restock();
        test_reset_midvend();
        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
